// File: rtl/layer_sequencer.sv
// Multi-layer run controller for the lenet accelerator: hands each layer's load to
// the DRAM loader, signals data ready, times the layer and watches for hangs.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start after reset
// EN    | one-cycle enable pulse to the accelerator
// LOAD  | load_req held for cur_layer until load_ack
// RDY   | one-cycle rdy_data pulse, layer cycle counter cleared
// WAIT  | counting until a fresh done_one_layer rising edge
// FIN   | last layer complete, waiting for the network done level
// DONE  | run finished, start begins a new run
// ERR   | WAIT/FIN timed out, left only through reset
module layer_sequencer #(
    parameter int NUM_LAYERS = 7,
    parameter int LAYER_W    = 3,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 100000
) (
    input  logic               clk,
    input  logic               srstn,
    input  logic               start,
    output logic               load_req,
    output logic [LAYER_W-1:0] load_layer,
    input  logic               load_ack,
    output logic               enable,
    output logic               rdy_data,
    input  logic               done_one_layer,
    input  logic               done,
    output logic [LAYER_W-1:0] cur_layer,
    output logic [CNT_W-1:0]   layer_cycles,
    output logic               layer_valid,
    output logic               busy,
    output logic               finished,
    output logic               timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_LOAD,
        S_RDY,
        S_WAIT,
        S_FIN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0]   CNT_TC     = CNT_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [LAYER_W-1:0]   r_cur_layer;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_dprev;
    logic [CNT_W-1:0]     r_layer_cycles;
    logic                 r_layer_valid;
    logic                 r_enable;
    logic                 r_load_req;
    logic [LAYER_W-1:0]   r_load_layer;
    logic                 r_rdy_data;
    logic                 r_busy;
    logic                 r_finished;
    logic                 r_timeout;

    state_t               w_state_nxt;
    logic [LAYER_W-1:0]   w_cur_layer_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CNT_W-1:0]     w_layer_cycles_nxt;
    logic                 w_layer_valid_nxt;
    logic                 w_edge;
    logic                 w_cnt_tc;
    logic                 w_last;

    // Only a fresh rising edge counts, so a level left high by the previous
    // layer can never complete the next one.
    assign w_edge    = done_one_layer & ~r_dprev;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cnt_tc  = (r_cnt == CNT_TC);
    assign w_last    = (r_cur_layer == LAST_LAYER);

    always_comb begin
        w_state_nxt        = r_state;
        w_cur_layer_nxt    = r_cur_layer;
        w_cnt_nxt          = r_cnt;
        w_layer_cycles_nxt = r_layer_cycles;
        w_layer_valid_nxt  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_EN;
                    w_cur_layer_nxt = '0;
                end
            end
            S_EN: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (load_ack) w_state_nxt = S_RDY;
            end
            S_RDY: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_edge) begin
                    w_layer_cycles_nxt = w_cnt_inc;
                    w_layer_valid_nxt  = 1'b1;
                    if (!w_last) begin
                        w_cur_layer_nxt = r_cur_layer + LAYER_W'(1);
                        w_state_nxt     = S_LOAD;
                    end else if (done) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FIN;
                    end
                end else if (w_cnt_tc) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_FIN: begin
                if (done) begin
                    w_state_nxt = S_DONE;
                end else if (w_cnt_tc) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_ERR: w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is valid for
    // exactly the cycles the FSM spends in the matching state.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_state        <= S_IDLE;
            r_cur_layer    <= '0;
            r_cnt          <= '0;
            r_dprev        <= 1'b0;
            r_layer_cycles <= '0;
            r_layer_valid  <= 1'b0;
            r_enable       <= 1'b0;
            r_load_req     <= 1'b0;
            r_load_layer   <= '0;
            r_rdy_data     <= 1'b0;
            r_busy         <= 1'b0;
            r_finished     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cur_layer    <= w_cur_layer_nxt;
            r_cnt          <= w_cnt_nxt;
            r_dprev        <= done_one_layer;
            r_layer_cycles <= w_layer_cycles_nxt;
            r_layer_valid  <= w_layer_valid_nxt;
            r_enable       <= (w_state_nxt == S_EN);
            r_load_req     <= (w_state_nxt == S_LOAD);
            r_load_layer   <= (w_state_nxt == S_LOAD) ? w_cur_layer_nxt : '0;
            r_rdy_data     <= (w_state_nxt == S_RDY);
            r_busy         <= (w_state_nxt inside {S_EN, S_LOAD, S_RDY, S_WAIT, S_FIN});
            r_finished     <= (w_state_nxt == S_DONE);
            r_timeout      <= (w_state_nxt == S_ERR);
        end
    end

    assign load_req     = r_load_req;
    assign load_layer   = r_load_layer;
    assign enable       = r_enable;
    assign rdy_data     = r_rdy_data;
    assign cur_layer    = r_cur_layer;
    assign layer_cycles = r_layer_cycles;
    assign layer_valid  = r_layer_valid;
    assign busy         = r_busy;
    assign finished     = r_finished;
    assign timeout      = r_timeout;

endmodule
